eg_operator: RTL and testbench



---
 rtl/eg_operator_pkg.sv | 28 ++
 rtl/eg_operator_tables.sv | 47 ++++
 rtl/eg_operator.sv | 160 ++++++++++++++++
 tb/tb_eg_operator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/eg_operator_pkg.sv
// Shared VM2413 operator types and constants: output sample type, attenuation
// limit, slot count and the per-channel feedback history record.
package vm2413;

  localparam int PHASE_BITS = 10;
  localparam int OUT_BITS   = 12;
  localparam int NUM_SLOTS  = 18;
  localparam logic [12:0] MAX_ATT = 13'h1FFF;

  typedef logic signed [OUT_BITS-1:0] SIGNED_OUT_TYPE;

  typedef struct packed {
    SIGNED_OUT_TYPE last;
    SIGNED_OUT_TYPE prev;
  } FB_MEM_TYPE;

  // Log-sine plus envelope attenuation, clamped to the largest representable value.
  function automatic logic [12:0] sat_att(input logic [12:0] ls, input logic [12:0] eg);
    logic [13:0] sum;
    sum = {1'b0, ls} + {1'b0, eg};
    if (sum[13]) begin
      return MAX_ATT;
    end else begin
      return sum[12:0];
    end
  endfunction

endpackage

// File: rtl/eg_operator_tables.sv
// Registered LOGSIN (256x13) and EXP (512x11) ROMs, both advanced by clkena.
// Contents are elaborated from their defining formulas.
module eg_operator_tables
  import vm2413::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkena,
  input  logic [7:0]  ls_addr_i,
  input  logic [8:0]  exp_addr_i,
  output logic [12:0] ls_o,
  output logic [10:0] exp_o
);

  localparam real PI = 3.14159265358979323846;

  logic [12:0] logsin_rom_s [256];
  logic [10:0] exp_rom_s    [512];
  logic [12:0] ls_q;
  logic [10:0] exp_q;

  for (genvar gi = 0; gi < 256; gi++) begin : g_logsin
    localparam real ANG = (gi + 0.5) * PI / 512.0;
    localparam int  LSV = $rtoi(-($ln($sin(ANG)) / $ln(2.0)) * 512.0 + 0.5);
    assign logsin_rom_s[gi] = LSV[12:0];
  end

  for (genvar gj = 0; gj < 512; gj++) begin : g_exp
    localparam int EXV = $rtoi(2047.0 * $pow(2.0, -gj / 512.0) + 0.5);
    assign exp_rom_s[gj] = EXV[10:0];
  end

  // ROM output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ls_q  <= 13'd0;
      exp_q <= 11'd0;
    end else if (clkena) begin
      ls_q  <= logsin_rom_s[ls_addr_i];
      exp_q <= exp_rom_s[exp_addr_i];
    end
  end

  assign ls_o  = ls_q;
  assign exp_o = exp_q;

endmodule

// File: rtl/eg_operator.sv
// VM2413 operator: phase modulation, log-sine, attenuation and exp conversion.
// EG_OP_FB_AVERAGE_EN selects two-sample (last+prev) modulator feedback.
module eg_operator
  import vm2413::*;
#(
  parameter int PHASE_W = PHASE_BITS,
  parameter int OUT_W   = OUT_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clkena,
  input  logic [4:0]       slot,
  input  logic [1:0]       stage,
  input  logic [17:0]      pgout,
  input  logic [12:0]      egout,
  input  logic             wf,
  input  logic [2:0]       fb,
  output logic [OUT_W-1:0] opout,
  output logic [4:0]       opslot
);

  localparam int NUM_CH = NUM_SLOTS / 2;

  logic [PHASE_W-1:0] pidx_q, pidx_d;
  logic [4:0]         slot_q;
  logic               valid_q;
  logic               sign_q;
  logic [3:0]         shift_q;
  logic [OUT_W-1:0]   opout_q;
  logic [4:0]         opslot_q;

  logic [7:0]         q_s;
  logic [12:0]        ls_s;
  logic [12:0]        a_s;
  logic [10:0]        exp_s;
  logic [10:0]        mag_s;
  logic [11:0]        mag_ext_s;
  SIGNED_OUT_TYPE     res_s;
  logic signed [12:0] mod_s;
  logic signed [12:0] fb_mod_s;
  logic [3:0]         rd_ch_s;
  logic [3:0]         wr_ch_s;
  logic               unused_pg_s;

`ifdef EG_OP_FB_AVERAGE_EN
  FB_MEM_TYPE         fbmem_q [NUM_CH];
  FB_MEM_TYPE         mem_rd_s;
  logic signed [12:0] fb_sum_s;
`else
  SIGNED_OUT_TYPE     fbmem_q [NUM_CH];
  SIGNED_OUT_TYPE     mem_rd_s;
`endif

  assign unused_pg_s = ^pgout[7:0];
  assign rd_ch_s     = slot[4:1];
  assign wr_ch_s     = slot_q[4:1];

  eg_operator_tables u_tables (
    .clk        (clk),
    .reset_n    (reset_n),
    .clkena     (clkena),
    .ls_addr_i  (q_s),
    .exp_addr_i (a_s[8:0]),
    .ls_o       (ls_s),
    .exp_o      (exp_s)
  );

  // Result of the slot completing on this stage-0 edge; feeds opout and the carrier bypass.
  always_comb begin
    mag_s     = exp_s >> shift_q;
    mag_ext_s = {1'b0, mag_s};
    res_s     = '0;
    if (!valid_q) begin
      res_s = '0;
    end else if (sign_q) begin
      res_s = -mag_ext_s;
    end else begin
      res_s = mag_ext_s;
    end
  end

  // Phase modulation: modulator self-feedback or carrier driven by its modulator.
  always_comb begin
    mem_rd_s = '0;
    if (int'(slot) < NUM_SLOTS) begin
      mem_rd_s = fbmem_q[rd_ch_s];
    end else begin
      mem_rd_s = '0;
    end
`ifdef EG_OP_FB_AVERAGE_EN
    fb_sum_s = $signed({mem_rd_s.last[OUT_BITS-1], mem_rd_s.last})
             + $signed({mem_rd_s.prev[OUT_BITS-1], mem_rd_s.prev});
    fb_mod_s = fb_sum_s >>> (4'd8 - {1'b0, fb});
`else
    fb_mod_s = $signed({mem_rd_s[OUT_BITS-1], mem_rd_s}) >>> (3'd7 - fb);
`endif
    mod_s = '0;
    if (slot[0]) begin
      mod_s = $signed({res_s[OUT_BITS-1], res_s}) >>> 1;
    end else if (fb == 3'd0) begin
      mod_s = '0;
    end else begin
      mod_s = fb_mod_s;
    end
    pidx_d = pgout[17 -: PHASE_W] + mod_s[PHASE_W-1:0];
  end

  // Quarter-wave folding and final attenuation with half-rectify mute.
  always_comb begin
    q_s = pidx_q[PHASE_W-2] ? ~pidx_q[PHASE_W-3:0] : pidx_q[PHASE_W-3:0];
    a_s = (wf && sign_q) ? MAX_ATT : sat_att(ls_s, egout);
  end

  // Per-stage pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pidx_q   <= '0;
      slot_q   <= 5'd0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      shift_q  <= 4'd0;
      opout_q  <= '0;
      opslot_q <= 5'd0;
    end else if (clkena) begin
      case (stage)
        2'd0: begin
          pidx_q   <= pidx_d;
          slot_q   <= slot;
          valid_q  <= 1'b1;
          opout_q  <= res_s;
          opslot_q <= slot_q;
        end
        2'd1:    sign_q  <= pidx_q[PHASE_W-1];
        2'd3:    shift_q <= a_s[12:9];
        default: ;
      endcase
    end
  end

  // Feedback history: a completing modulator shifts in its new sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        fbmem_q[i] <= '0;
      end
    end else if (clkena && stage == 2'd0 && valid_q && !slot_q[0]
                 && int'(slot_q) < NUM_SLOTS) begin
`ifdef EG_OP_FB_AVERAGE_EN
      fbmem_q[wr_ch_s].prev <= fbmem_q[wr_ch_s].last;
      fbmem_q[wr_ch_s].last <= res_s;
`else
      fbmem_q[wr_ch_s] <= res_s;
`endif
    end
  end

  assign opout  = opout_q;
  assign opslot = opslot_q;

endmodule

// File: tb/tb_eg_operator.sv
// Self-checking bench for eg_operator: directed scenarios plus randomized slots
// checked against a formula-level operator model.
module tb_eg_operator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clkena;
  logic [4:0]  slot;
  logic [1:0]  stage;
  logic [17:0] pgout;
  logic [12:0] egout;
  logic        wf;
  logic [2:0]  fb;
  logic [11:0] opout;
  logic [4:0]  opslot;

  always #5 clk = ~clk;

  eg_operator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clkena  (clkena),
    .slot    (slot),
    .stage   (stage),
    .pgout   (pgout),
    .egout   (egout),
    .wf      (wf),
    .fb      (fb),
    .opout   (opout),
    .opslot  (opslot)
  );

  int n_vec = 0;
  int n_err = 0;
  int last_m [9];
`ifdef EG_OP_FB_AVERAGE_EN
  int prev_m [9];
`endif
  bit pend_valid;
  int pend_slot;
  int pend_val;
  int cs;

  localparam real PI = 3.14159265358979323846;

  function automatic int logsin_ref(input int i);
    real x;
    x = (i + 0.5) * PI / 512.0;
    return $rtoi(-($ln($sin(x)) / $ln(2.0)) * 512.0 + 0.5);
  endfunction

  function automatic int exp_ref(input int j);
    return $rtoi(2047.0 * $pow(2.0, -j / 512.0) + 0.5);
  endfunction

  // Full operator output for a given 10-bit phase, attenuation and waveform.
  function automatic int op_ref(input int pidx, input int eg, input bit w);
    int q;
    int a;
    int mag;
    bit neg;
    neg = (pidx >= 512);
    q = ((pidx / 256) % 2 == 1) ? 255 - (pidx % 256) : pidx % 256;
    a = logsin_ref(q) + eg;
    if (a > 8191) a = 8191;
    if (w && neg) a = 8191;
    mag = exp_ref(a % 512) / (1 << (a / 512));
    return neg ? -mag : mag;
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(expv));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 9; i++) begin
      last_m[i] = 0;
`ifdef EG_OP_FB_AVERAGE_EN
      prev_m[i] = 0;
`endif
    end
    pend_valid = 1'b0;
    pend_slot  = 0;
    pend_val   = 0;
  endtask

  // One clkena stage, sometimes preceded by a stalled cycle carrying junk inputs.
  task automatic tick();
    logic [4:0]  s0;
    logic [1:0]  t0;
    logic [17:0] p0;
    logic [12:0] e0;
    if ($urandom_range(0, 3) == 0) begin
      s0 = slot; t0 = stage; p0 = pgout; e0 = egout;
      clkena = 1'b0;
      slot   = 5'($urandom_range(0, 17));
      stage  = 2'($urandom);
      pgout  = 18'($urandom);
      egout  = 13'($urandom);
      @(posedge clk); #1;
      slot = s0; stage = t0; pgout = p0; egout = e0;
      clkena = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_slot(input int s, input int pg, input int eg, input bit w,
                          input int f, input bit abort);
    int ch;
    int modv;
    int mcur;
    int pidx;
    int res;
    ch = s / 2;
    if (pend_valid && pend_slot % 2 == 0) begin
`ifdef EG_OP_FB_AVERAGE_EN
      prev_m[pend_slot / 2] = last_m[pend_slot / 2];
`endif
      last_m[pend_slot / 2] = pend_val;
    end
    mcur = (pend_valid && pend_slot == s - 1) ? pend_val : 0;
    if (s % 2 == 1) begin
      modv = mcur >>> 1;
    end else if (f == 0) begin
      modv = 0;
    end else begin
`ifdef EG_OP_FB_AVERAGE_EN
      modv = (last_m[ch] + prev_m[ch]) >>> (8 - f);
`else
      modv = last_m[ch] >>> (7 - f);
`endif
    end
    pidx = (pg + modv) & 1023;
    res  = op_ref(pidx, eg, w);

    slot  = 5'(s);
    stage = 2'd0;
    pgout = {10'(pg), 8'($urandom)};
    egout = 13'(eg);
    wf    = w;
    fb    = 3'(f);
    tick();
    check("opout", opout, 12'(pend_valid ? pend_val : 0));
    check("opslot", {7'd0, opslot}, 12'(pend_valid ? pend_slot : 0));
    pend_valid = 1'b1;
    pend_slot  = s;
    pend_val   = res;
    for (int t = 1; t < 4; t++) begin
      stage = 2'(t);
      tick();
      if (abort && t == 2) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_opout", opout, 12'd0);
        check("rst_mid_opslot", {7'd0, opslot}, 12'd0);
        clear_model();
        #2 reset_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic nxt(input int pg, input int eg, input bit w, input int f);
    run_slot(cs, pg, eg, w, f, 1'b0);
    cs = (cs + 1) % 18;
  endtask

  task automatic nxt_rand();
    int eg;
    eg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 1200));
    nxt(int'($urandom_range(0, 1023)), eg, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; clkena = 1'b0; slot = 5'd0; stage = 2'd0;
    pgout = 18'd0; egout = 13'd0; wf = 1'b0; fb = 3'd0;
    clear_model();
    cs = 0;
    #2;
    check("rst_opout", opout, 12'd0);
    check("rst_opslot", {7'd0, opslot}, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clkena  = 1'b1;

    nxt(256, 0, 1'b0, 0);
    nxt(0, 0, 1'b0, 0);
    check("peak", opout, 12'd2047);
    nxt(768, 512, 1'b0, 0);
    check("bypass", opout, 12'(-6));
    nxt_rand();
    check("neg_half", opout, 12'(-1023));
    nxt(768, 8191, 1'b0, 0);
    nxt_rand();
    check("att_max", opout, 12'd0);
    nxt(768, 0, 1'b1, 0);
    nxt_rand();
    check("half_rect", opout, 12'd0);
    nxt(768, 0, 1'b0, 0);
    nxt_rand();
    check("full_neg", opout, 12'(-2047));

    nxt(256, 511, 1'b0, 0);
    while (cs != 10) nxt_rand();
    nxt(256, 511, 1'b0, 0);
    while (cs != 10) nxt_rand();
    nxt(100, 0, 1'b0, 7);
    nxt_rand();
    check("fb_wrap", opout, 12'(op_ref(101, 0, 1'b0)));

    repeat (90) nxt_rand();

    while (cs != 12) nxt_rand();
    run_slot(12, 300, 100, 1'b0, 3, 1'b1);
    cs = 13;
    nxt(0, 0, 1'b0, 0);
    nxt_rand();
    check("post_reset", opout, 12'd6);

    repeat (20) nxt_rand();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
